// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage with IF/ID register and halt FSM
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   stall            decode not ready; PC and IF/ID hold
//   redirect         taken branch/jump; load redirect_pc, flush IF/ID
//   redirect_pc      redirect target (word index)
//   inst_in          instruction memory data for pc_out (same-cycle)
//   pc_out           fetch address (word index)
//   if_id_inst/pc    registered instruction and its PC
//   if_id_valid      IF/ID holds a real instruction
//   halted           FSM is in HALT
//   fetch_count      valid instructions delivered (FETCH_PERF_CNT_EN only, else 0)
//   stall_count      RUN cycles stalled (FETCH_PERF_CNT_EN only, else 0)
// Macro FETCH_PERF_CNT_EN enables the performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q, inst_q, ipc_q;
    logic        valid_q, halted_q;
    logic        is_halt;

    assign is_halt     = inst_in == HALT_WORD;
    assign pc_out      = pc_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc    = ipc_q;
    assign if_id_valid = valid_q;
    assign halted      = halted_q;

    // Redirect outranks every state, stall and halt detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else if (redirect) begin
            state_q  <= RUN;
            pc_q     <= redirect_pc;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= RUN;
                    valid_q <= 1'b0;
                end
                RUN: begin
                    if (!stall) begin
                        if (is_halt) begin
                            state_q  <= HALT;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            inst_q  <= inst_in;
                            ipc_q   <= pc_q;
                            valid_q <= 1'b1;
                            pc_q    <= pc_q + 32'd1;
                        end
                    end
                end
                HALT: valid_q <= 1'b0;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
    logic        run_ok;

    assign run_ok      = !redirect && state_q == RUN;
    assign fetch_cnt_d = fetch_cnt_q + {31'd0, run_ok && !stall && !is_halt};
    assign stall_cnt_d = stall_cnt_q + {31'd0, run_ok && stall};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, rst, stall, redirect, if_id_valid, halted;
    logic [31:0] redirect_pc, inst_in, pc_out, if_id_inst, if_id_pc, fetch_count, stall_count;
    logic [31:0] mem [64];
    int total = 0, bad = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_in(inst_in), .pc_out(pc_out),
        .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .halted(halted), .fetch_count(fetch_count), .stall_count(stall_count)
    );

    assign inst_in = mem[pc_out[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_exp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0]  = 32'h11;
        mem[1]  = 32'h22;
        mem[2]  = 32'h33;
        mem[3]  = 32'hFFFF_FFFF;
        mem[16] = 32'hA0;
        mem[63] = 32'hEE;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        step();
        step();
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_inst", if_id_inst, 32'd0);
        chk("rst_ipc", if_id_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fcnt", fetch_count, 32'd0);
        chk("rst_scnt", stall_count, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_valid", {31'd0, if_id_valid}, 32'd0);
        chk("idle_pc", pc_out, 32'd0);
        step();
        chk("f0_inst", if_id_inst, 32'h11);
        chk("f0_ipc", if_id_pc, 32'd0);
        chk("f0_valid", {31'd0, if_id_valid}, 32'd1);
        step();
        chk("f1_inst", if_id_inst, 32'h22);
        chk("f1_ipc", if_id_pc, 32'd1);
        chk("f1_pc", pc_out, 32'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_inst", if_id_inst, 32'h22);
            chk("stall_pc", pc_out, 32'd2);
            chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
        end
        chk("stall_cnt", stall_count, pc_exp(3));
        chk("fetch_cnt2", fetch_count, pc_exp(2));
        stall = 1'b0;
        step();
        chk("f2_inst", if_id_inst, 32'h33);
        chk("f2_ipc", if_id_pc, 32'd2);
        chk("f2_pc", pc_out, 32'd3);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
            chk("halt_pc", pc_out, 32'd3);
        end
        chk("halt_fcnt", fetch_count, pc_exp(3));
        redirect = 1'b1; redirect_pc = 32'd0;
        step();
        redirect = 1'b0;
        chk("rdh_halted", {31'd0, halted}, 32'd0);
        chk("rdh_pc", pc_out, 32'd0);
        chk("rdh_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("rs_inst", if_id_inst, 32'h11);
        chk("rs_valid", {31'd0, if_id_valid}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h10; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk("rds_pc", pc_out, 32'h10);
        chk("rds_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rds_scnt", stall_count, pc_exp(3));
        step();
        chk("rds_ipc", if_id_pc, 32'h10);
        chk("rds_inst", if_id_inst, 32'hA0);
        chk("rds_valid2", {31'd0, if_id_valid}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        chk("wr_pc", pc_out, 32'hFFFF_FFFF);
        step();
        chk("wr_ipc", if_id_pc, 32'hFFFF_FFFF);
        chk("wr_inst", if_id_inst, 32'hEE);
        chk("wr_pc0", pc_out, 32'd0);
        step();
        chk("wr_next", if_id_inst, 32'h11);
        chk("wr_fcnt", fetch_count, pc_exp(7));
        stall = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("ar_pc", pc_out, 32'd0);
        chk("ar_inst", if_id_inst, 32'd0);
        chk("ar_ipc", if_id_pc, 32'd0);
        chk("ar_valid", {31'd0, if_id_valid}, 32'd0);
        chk("ar_fcnt", fetch_count, 32'd0);
        chk("ar_scnt", stall_count, 32'd0);
        step();
        #2 rst = 1'b0; stall = 1'b0;
        step();
        chk("ar_idle_valid", {31'd0, if_id_valid}, 32'd0);
        chk("ar_idle_pc", pc_out, 32'd0);
        step();
        chk("ar_f0_inst", if_id_inst, 32'h11);
        chk("ar_f0_valid", {31'd0, if_id_valid}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
